// File: rtl/out_ctl.sv
// rtl/out_ctl.sv - result FIFO and AXI-Stream-style drain for the conv output path
// Optional build macro OUT_CTL_RELU_EN clamps negative results to zero on push.
module out_ctl #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [4:0]   sample,
  input  logic         s_init,
  input  logic         k_fin,
  input  logic [W-1:0] acc,
  output logic         out_busy,
  output logic         outrf,
  output logic         dst_valid,
  input  logic         dst_ready,
  output logic [W-1:0] dst_data,
  output logic         dst_last,
  output logic         done,
  output logic         err
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [CW-1:0] HIGH = CW'(DEPTH - 1);

  logic [W-1:0]     mem_data [DEPTH];
  logic [DEPTH-1:0] mem_last;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic [4:0]       idx;
  logic [4:0]       sample_q;

  logic       pop;
  logic       overflow;
  logic       push_ok;
  logic       push_last;
  logic [4:0] idx_cur;
  logic [4:0] sample_cur;
  logic [W-1:0] push_data;

  assign dst_valid = (cnt != '0);
  assign outrf     = (cnt == '0);
  // Busy one slot early so a pass already in flight still has room.
  assign out_busy  = (cnt >= HIGH);
  assign dst_data  = mem_data[rd_ptr];
  assign dst_last  = mem_last[rd_ptr];

  always_comb begin
    // A push in the same cycle as s_init belongs to the new pass.
    idx_cur    = s_init ? 5'd0 : idx;
    sample_cur = s_init ? sample : sample_q;
    push_last  = (idx_cur == sample_cur);
    pop        = dst_valid && dst_ready;
    overflow   = k_fin && (cnt == FULL) && !pop;
    push_ok    = k_fin && !overflow;
`ifdef OUT_CTL_RELU_EN
    push_data  = acc[W-1] ? '0 : acc;
`else
    push_data  = acc;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_data[i] <= '0;
      mem_last <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      idx      <= '0;
      sample_q <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      if (push_ok) begin
        mem_data[wr_ptr] <= push_data;
        mem_last[wr_ptr] <= push_last;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;

      if (push_ok && !pop)      cnt <= cnt + 1'b1;
      else if (!push_ok && pop) cnt <= cnt - 1'b1;

      if (push_ok) idx <= push_last ? 5'd0 : idx_cur + 5'd1;
      else         idx <= idx_cur;

      if (s_init) sample_q <= sample;

      done <= pop && dst_last;

      if (s_init)        err <= 1'b0;
      else if (overflow) err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_out_ctl.sv
// tb/tb_out_ctl.sv - table vectors plus queue scoreboard for out_ctl
module tb_out_ctl;
  localparam int W = 16;
  localparam int DEPTH = 4;

  logic         clk;
  logic         rst;
  logic [4:0]   sample;
  logic         s_init;
  logic         k_fin;
  logic [W-1:0] acc;
  logic         out_busy;
  logic         outrf;
  logic         dst_valid;
  logic         dst_ready;
  logic [W-1:0] dst_data;
  logic         dst_last;
  logic         done;
  logic         err;

  out_ctl #(.W(W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .sample(sample), .s_init(s_init), .k_fin(k_fin),
    .acc(acc), .out_busy(out_busy), .outrf(outrf), .dst_valid(dst_valid),
    .dst_ready(dst_ready), .dst_data(dst_data), .dst_last(dst_last),
    .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       si;
    logic       kf;
    logic [15:0] a;
    logic       rdy;
    logic [4:0] smp;
    logic       eb;
    logic       eo;
    logic       ed;
    logic       ee;
  } vec_t;

  int total = 0;
  int bad = 0;

  logic [W:0] m_q[$];
  logic [4:0] m_idx = 0;
  logic [4:0] m_sample = 0;
  logic       m_err = 0;
  logic       m_done = 0;

  vec_t tv;
  logic tbl_on = 0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", n, act, exp, $time);
    end
  endtask

  // One cycle: drive at negedge, check just after, model the edge, return at next negedge.
  task automatic step(input logic si, input logic kf, input logic [15:0] a,
                      input logic rdy, input logic [4:0] smp);
    logic pop_m, ovf, last_m, nd;
    logic [4:0] ic, sc;
    logic [15:0] d;
    sample = smp; s_init = si; k_fin = kf; acc = a; dst_ready = rdy;
    #1;
    chk("valid", dst_valid, m_q.size() != 0);
    chk("outrf", outrf, m_q.size() == 0);
    chk("busy", out_busy, m_q.size() >= DEPTH - 1);
    chk("done", done, m_done);
    chk("err", err, m_err);
    if (m_q.size() != 0) begin
      chk("data", dst_data, m_q[0][W-1:0]);
      chk("last", dst_last, m_q[0][W]);
    end
    if (tbl_on) begin
      chk("tbl_busy", out_busy, tv.eb);
      chk("tbl_outrf", outrf, tv.eo);
      chk("tbl_done", done, tv.ed);
      chk("tbl_err", err, tv.ee);
    end
    pop_m = (m_q.size() != 0) && rdy;
    ic = si ? 5'd0 : m_idx;
    sc = si ? smp : m_sample;
    last_m = (ic == sc);
`ifdef OUT_CTL_RELU_EN
    d = a[15] ? 16'd0 : a;
`else
    d = a;
`endif
    ovf = kf && (m_q.size() == DEPTH) && !pop_m;
    nd = 1'b0;
    if (pop_m) begin
      nd = m_q[0][W];
      void'(m_q.pop_front());
    end
    if (kf && !ovf) begin
      m_q.push_back({last_m, d});
      m_idx = last_m ? 5'd0 : ic + 5'd1;
    end else begin
      m_idx = ic;
    end
    m_sample = sc;
    if (si) m_err = 1'b0;
    else if (ovf) m_err = 1'b1;
    @(posedge clk);
    m_done = nd;
    @(negedge clk);
  endtask

  vec_t tbl[$];

  initial begin
    rst = 1'b0; sample = 0; s_init = 0; k_fin = 0; acc = 0; dst_ready = 0;
    // basic pass, sample=2, sink always ready
    tbl.push_back('{1,0,16'd0,1,5'd2, 0,1,0,0});
    tbl.push_back('{0,1,16'd5,1,5'd2, 0,1,0,0});
    tbl.push_back('{0,1,16'hFFFD,1,5'd2, 0,0,0,0});
    tbl.push_back('{0,1,16'd7,1,5'd2, 0,0,0,0});
    tbl.push_back('{0,0,16'd0,1,5'd2, 0,0,0,0});
    tbl.push_back('{0,0,16'd0,1,5'd2, 0,1,1,0});
    tbl.push_back('{0,0,16'd0,1,5'd2, 0,1,0,0});
    // same pass, sink stalled, then released
    tbl.push_back('{1,0,16'd0,0,5'd2, 0,1,0,0});
    tbl.push_back('{0,1,16'd5,0,5'd2, 0,1,0,0});
    tbl.push_back('{0,1,16'hFFFD,0,5'd2, 0,0,0,0});
    tbl.push_back('{0,1,16'd7,0,5'd2, 0,0,0,0});
    tbl.push_back('{0,0,16'd0,0,5'd2, 1,0,0,0});
    tbl.push_back('{0,0,16'd0,1,5'd2, 1,0,0,0});
    tbl.push_back('{0,0,16'd0,1,5'd2, 0,0,0,0});
    tbl.push_back('{0,0,16'd0,1,5'd2, 0,0,0,0});
    tbl.push_back('{0,0,16'd0,1,5'd2, 0,1,1,0});
    // fill to full, push+pop while full, then overflow
    tbl.push_back('{1,0,16'd0,0,5'd7, 0,1,0,0});
    tbl.push_back('{0,1,16'd10,0,5'd7, 0,1,0,0});
    tbl.push_back('{0,1,16'd11,0,5'd7, 0,0,0,0});
    tbl.push_back('{0,1,16'd12,0,5'd7, 0,0,0,0});
    tbl.push_back('{0,1,16'd13,0,5'd7, 1,0,0,0});
    tbl.push_back('{0,1,16'd14,1,5'd7, 1,0,0,0});
    tbl.push_back('{0,0,16'd0,0,5'd7, 1,0,0,0});
    tbl.push_back('{0,1,16'd99,0,5'd7, 1,0,0,0});
    tbl.push_back('{0,0,16'd0,0,5'd7, 1,0,0,1});
    tbl.push_back('{0,0,16'd0,1,5'd7, 1,0,0,1});
    tbl.push_back('{0,0,16'd0,1,5'd7, 1,0,0,1});
    tbl.push_back('{0,0,16'd0,1,5'd7, 0,0,0,1});
    tbl.push_back('{0,0,16'd0,1,5'd7, 0,0,0,1});
    // idx must still be 5: the third of these carries last
    tbl.push_back('{0,1,16'd20,1,5'd7, 0,1,0,1});
    tbl.push_back('{0,1,16'd21,1,5'd7, 0,0,0,1});
    tbl.push_back('{0,1,16'd22,1,5'd7, 0,0,0,1});
    tbl.push_back('{0,0,16'd0,1,5'd7, 0,0,0,1});
    tbl.push_back('{0,0,16'd0,1,5'd7, 0,1,1,1});
    tbl.push_back('{1,0,16'd0,1,5'd0, 0,1,0,1});
    tbl.push_back('{0,0,16'd0,1,5'd0, 0,1,0,0});
    // sample=0: every beat is last
    tbl.push_back('{1,0,16'd0,1,5'd0, 0,1,0,0});
    tbl.push_back('{0,1,16'd1,1,5'd0, 0,1,0,0});
    tbl.push_back('{0,1,16'd2,1,5'd0, 0,0,0,0});
    tbl.push_back('{0,1,16'd3,1,5'd0, 0,0,1,0});
    tbl.push_back('{0,0,16'd0,1,5'd0, 0,0,1,0});
    tbl.push_back('{0,0,16'd0,1,5'd0, 0,1,1,0});
    tbl.push_back('{0,0,16'd0,1,5'd0, 0,1,0,0});

    repeat (2) @(negedge clk);
    chk("rst_valid", dst_valid, 1'b0);
    chk("rst_outrf", outrf, 1'b1);
    chk("rst_busy", out_busy, 1'b0);
    chk("rst_data", dst_data, 16'd0);
    chk("rst_last", dst_last, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    rst = 1'b1;

    tbl_on = 1'b1;
    foreach (tbl[i]) begin
      tv = tbl[i];
      step(tv.si, tv.kf, tv.a, tv.rdy, tv.smp);
    end
    tbl_on = 1'b0;

    for (int c = 0; c < 300; c++) begin
      step($urandom_range(0, 24) == 0, $urandom_range(0, 1) == 1,
           16'($urandom), $urandom_range(0, 2) != 0, 5'($urandom_range(0, 3)));
    end

    for (int c = 0; c < 10 && m_q.size() != 0; c++) step(0, 0, 16'd0, 1, 5'd0);
    chk("drained", m_q.size(), 0);
    step(1, 0, 16'd0, 0, 5'd3);
    step(0, 1, 16'd40, 0, 5'd3);
    step(0, 1, 16'd41, 0, 5'd3);
    chk("pre_rst_valid", dst_valid, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("async_valid", dst_valid, 1'b0);
    chk("async_outrf", outrf, 1'b1);
    chk("async_busy", out_busy, 1'b0);
    chk("async_data", dst_data, 16'd0);
    m_q.delete();
    m_idx = 0; m_sample = 0; m_err = 0; m_done = 0;
    @(negedge clk);
    rst = 1'b1;
    step(0, 0, 16'd0, 1, 5'd0);
    step(1, 0, 16'd0, 1, 5'd1);
    step(0, 1, 16'd8, 1, 5'd1);
    step(0, 1, 16'd9, 1, 5'd1);
    step(0, 0, 16'd0, 1, 5'd1);
    step(0, 0, 16'd0, 1, 5'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
